// File: rtl/button_conditioner.sv
// Pushbutton front end: polarity fix, two-flop synchroniser and a debounce FSM per
// button, then a latched one-hot ALU selection and single-cycle press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_alu_raw,
  input  logic       btn_mode_raw,
  output logic [3:0] alu_level,
  output logic       alu_any,
  output logic [3:0] alu_sel,
  output logic       alu_new,
  output logic       mode_level,
  output logic       mode_pulse
);

  localparam int NB = 5;
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  // Bits 3:0 are the ALU buttons, bit 4 is the mode button.
  logic [NB-1:0] pressed_raw;
  logic [NB-1:0] sync1_d, sync1_q;
  logic [NB-1:0] sync2_d, sync2_q;
  logic [NB-1:0] evt_d, evt_q;
  logic [NB-1:0] level_d, level_q;
  btn_state_e    state_d [NB];
  btn_state_e    state_q [NB];
  logic [CW-1:0] cnt_d   [NB];
  logic [CW-1:0] cnt_q   [NB];
  logic [3:0]    alu_sel_d, alu_sel_q;
  logic          alu_new_d, alu_new_q;
  logic          mode_pulse_d, mode_pulse_q;

  assign pressed_raw = ACTIVE_LOW ? ~{btn_mode_raw, btn_alu_raw} : {btn_mode_raw, btn_alu_raw};

  always_comb begin
    sync1_d = pressed_raw;
    sync2_d = sync1_q;
  end

  always_comb begin
    evt_d   = '0;
    level_d = '0;
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = (state_q[i] == HELD) || (state_q[i] == RELEASE_CHK);
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = HELD;
            evt_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Press events are registered once more so pulses align with the level rising.
  always_comb begin
    alu_sel_d    = alu_sel_q;
    alu_new_d    = |evt_q[3:0];
    mode_pulse_d = evt_q[4];
    if (|evt_q[3:0]) begin
      alu_sel_d = evt_q[3:0] & (~evt_q[3:0] + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      evt_q        <= '0;
      level_q      <= '0;
      alu_sel_q    <= '0;
      alu_new_q    <= 1'b0;
      mode_pulse_q <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      evt_q        <= evt_d;
      level_q      <= level_d;
      alu_sel_q    <= alu_sel_d;
      alu_new_q    <= alu_new_d;
      mode_pulse_q <= mode_pulse_d;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign alu_level  = level_q[3:0];
  assign alu_any    = |level_q[3:0];
  assign alu_sel    = alu_sel_q;
  assign alu_new    = alu_new_q;
  assign mode_level = level_q[4];
  assign mode_pulse = mode_pulse_q;

endmodule
